// File: rtl/clint_reg_ctrl.sv
// -----------------------------------------------------------------------------
// clint_reg_ctrl
// -----------------------------------------------------------------------------
// Memory-mapped register controller for the CLINT. It owns the machine timer
// (count / mtime), the timer compare value (countcmp / mtimecmp) and the
// software interrupt bit (msip). It serves single-outstanding 32-bit
// load/store requests from the core's peripheral port. It also advances count
// on every trigger_edge tick from the always-on timer while cnt_en is high.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x0000  msip         bit0 only, other bits read as zero / ignore writes
//   0x4000  countcmp lo
//   0x4004  countcmp hi
//   0xBFF8  count lo
//   0xBFFC  count hi
//   other   writes ignored, reads return 0, rsp_err = 1
//
// Ports:
//   clk          in   core clock
//   rst          in   asynchronous reset, active-high
//   req_valid    in   request present
//   req_ready    out  controller can accept a request (high only in IDLE)
//   req_we       in   1 = write, 0 = read
//   req_addr     in   [ADDR_W-1:0] byte offset
//   req_wdata    in   [31:0] write data
//   req_wstrb    in   [3:0] byte enables for writes
//   rsp_valid    out  response present (high only in RESP)
//   rsp_ready    in   requester takes the response
//   rsp_rdata    out  [31:0] read data (0 on writes and errors)
//   rsp_err      out  unmapped offset
//   cnt_en       in   1 = count runs, 0 = count frozen (debug halt)
//   trigger_edge in   one-cycle tick from the CLINT timer
//   count        out  [63:0] mtime
//   countcmp     out  [63:0] mtimecmp
//   msip         out  [63:0] {63'b0, msip bit}
//   dbg_state    out  current FSM state (0 = IDLE, 1 = RESP)
//
// Handshake: a request transfers on a clock edge where req_valid && req_ready.
// A response transfers on a clock edge where rsp_valid && rsp_ready. While
// rsp_valid is high, rsp_rdata and rsp_err hold steady. rsp_* come only from
// flops and FSM state, so there is no combinational path from req_* to rsp_*.
// -----------------------------------------------------------------------------
module clint_reg_ctrl #(
    parameter int          ADDR_W   = 16,
    parameter logic [63:0] INC_STEP = 64'd1,
    parameter logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic              cnt_en,
    input  logic              trigger_edge,
    output logic [63:0]       count,
    output logic [63:0]       countcmp,
    output logic [63:0]       msip,
    output logic              dbg_state
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] A_MSIP   = ADDR_W'(16'h0000);
    localparam logic [ADDR_W-1:0] A_CMP_LO = ADDR_W'(16'h4000);
    localparam logic [ADDR_W-1:0] A_CMP_HI = ADDR_W'(16'h4004);
    localparam logic [ADDR_W-1:0] A_CNT_LO = ADDR_W'(16'hBFF8);
    localparam logic [ADDR_W-1:0] A_CNT_HI = ADDR_W'(16'hBFFC);
    // Clears the byte-lane bits so that any addr[1:0] selects the same word.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [63:0]       r_count;
    logic [63:0]       r_countcmp;
    logic              r_msip;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic [ADDR_W-1:0] w_addr_word;
    logic              w_sel_msip;
    logic              w_sel_cmp_lo;
    logic              w_sel_cmp_hi;
    logic              w_sel_cnt_lo;
    logic              w_sel_cnt_hi;
    logic              w_hit;
    logic [31:0]       w_rd_data;
    logic              w_acc;
    logic              w_wr;
    logic              w_tick;

    // Per-byte merge of write data into an existing 32-bit word.
    function automatic logic [31:0] f_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Address decode and read mux (values as they stand at the accept edge)
    // ------------------------------------------------------------------
    always_comb begin
        w_addr_word  = req_addr & WORD_MASK;
        w_sel_msip   = (w_addr_word == A_MSIP);
        w_sel_cmp_lo = (w_addr_word == A_CMP_LO);
        w_sel_cmp_hi = (w_addr_word == A_CMP_HI);
        w_sel_cnt_lo = (w_addr_word == A_CNT_LO);
        w_sel_cnt_hi = (w_addr_word == A_CNT_HI);
        w_hit        = w_sel_msip | w_sel_cmp_lo | w_sel_cmp_hi |
                       w_sel_cnt_lo | w_sel_cnt_hi;

        w_rd_data = 32'h0;
        if (w_sel_msip) begin
            w_rd_data = {31'b0, r_msip};
        end else if (w_sel_cmp_lo) begin
            w_rd_data = r_countcmp[31:0];
        end else if (w_sel_cmp_hi) begin
            w_rd_data = r_countcmp[63:32];
        end else if (w_sel_cnt_lo) begin
            w_rd_data = r_count[31:0];
        end else if (w_sel_cnt_hi) begin
            w_rd_data = r_count[63:32];
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_acc  = req_valid && req_ready;
    assign w_wr   = w_acc && req_we;
    assign w_tick = cnt_en && trigger_edge;

    // ------------------------------------------------------------------
    // Response registers: captured at the accept edge, held through RESP,
    // cleared once the response has been taken.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (w_acc) begin
            r_rsp_rdata <= req_we ? 32'h0 : w_rd_data;
            r_rsp_err   <= ~w_hit;
        end else if (rsp_valid && rsp_ready) begin
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // count: a bus write to either half beats a same-cycle tick. The tick
    // is dropped and the untouched half keeps its old value. The add is
    // a full 64-bit add, so carry crosses halves and all-ones wraps to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 64'h0;
        end else if (w_wr && w_sel_cnt_lo) begin
            r_count[31:0] <= f_merge(r_count[31:0], req_wdata, req_wstrb);
        end else if (w_wr && w_sel_cnt_hi) begin
            r_count[63:32] <= f_merge(r_count[63:32], req_wdata, req_wstrb);
        end else if (w_tick) begin
            r_count <= r_count + INC_STEP;
        end
    end

    // ------------------------------------------------------------------
    // countcmp
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_countcmp <= CMP_RST;
        end else if (w_wr && w_sel_cmp_lo) begin
            r_countcmp[31:0] <= f_merge(r_countcmp[31:0], req_wdata, req_wstrb);
        end else if (w_wr && w_sel_cmp_hi) begin
            r_countcmp[63:32] <= f_merge(r_countcmp[63:32], req_wdata, req_wstrb);
        end
    end

    // ------------------------------------------------------------------
    // msip: only bit0 exists, so only byte lane 0 can change it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msip <= 1'b0;
        end else if (w_wr && w_sel_msip && req_wstrb[0]) begin
            r_msip <= req_wdata[0];
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign count     = r_count;
    assign countcmp  = r_countcmp;
    assign msip      = {63'b0, r_msip};
    assign dbg_state = r_state;

endmodule

// File: tb/tb_clint_reg_ctrl.sv
module tb_clint_reg_ctrl;

    localparam logic [63:0] INC     = 64'd1;
    localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        cnt_en, trigger_edge;
    logic [63:0] count, countcmp, msip;
    logic        dbg_state;

    always #5 clk = ~clk;

    clint_reg_ctrl #(
        .ADDR_W  (16),
        .INC_STEP(INC),
        .CMP_RST (CMP_RST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .cnt_en      (cnt_en),
        .trigger_edge(trigger_edge),
        .count       (count),
        .countcmp    (countcmp),
        .msip        (msip),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard and reference model ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [32:0] exp_q[$];      // {err, rdata}
    logic [32:0] mon_exp;

    logic [63:0] m_count;
    logic [63:0] m_cmp;
    logic        m_msip;
    logic        m_pend;        // a response is outstanding

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] put_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        m_count = 64'h0;
        m_cmp   = CMP_RST;
        m_msip  = 1'b0;
        m_pend  = 1'b0;
    endfunction

    // Applies one accepted access to the model and queues the expected response.
    task automatic model_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                                input logic [3:0] ws, output logic cnt_written);
        logic [15:0] a;
        logic [31:0] rd;
        logic        err;
        a = addr & 16'hFFFC;
        rd = 32'h0;
        err = 1'b0;
        cnt_written = 1'b0;
        case (a)
            16'h0000: rd = {31'b0, m_msip};
            16'h4000: rd = m_cmp[31:0];
            16'h4004: rd = m_cmp[63:32];
            16'hBFF8: rd = m_count[31:0];
            16'hBFFC: rd = m_count[63:32];
            default:  err = 1'b1;
        endcase
        exp_q.push_back({err, we ? 32'h0 : rd});
        if (we) begin
            case (a)
                16'h0000: if (ws[0]) m_msip = wd[0];
                16'h4000: m_cmp[31:0]  = put_bytes(m_cmp[31:0], wd, ws);
                16'h4004: m_cmp[63:32] = put_bytes(m_cmp[63:32], wd, ws);
                16'hBFF8: begin m_count[31:0]  = put_bytes(m_count[31:0], wd, ws);  cnt_written = 1'b1; end
                16'hBFFC: begin m_count[63:32] = put_bytes(m_count[63:32], wd, ws); cnt_written = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: inputs are driven just after a rising edge. Outputs
    // are checked against the model at the falling edge. The model then
    // advances to its state after the next rising edge.
    task automatic step(input logic v, input logic we, input logic [15:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws, input logic tk,
                        input logic en, input logic rr, output logic acc);
        logic cw;
        req_valid = v; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        trigger_edge = tk; cnt_en = en; rsp_ready = rr;
        @(negedge clk);
        chk("req_ready", 64'(req_ready), 64'(!m_pend));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_pend));
        chk("count", count, m_count);
        chk("countcmp", countcmp, m_cmp);
        chk("msip", msip, {63'b0, m_msip});
        acc = v && !m_pend;
        cw = 1'b0;
        if (m_pend && rr) m_pend = 1'b0;
        if (acc) begin
            model_access(we, addr, wd, ws, cw);
            m_pend = 1'b1;
        end
        if (tk && en && !cw) m_count = m_count + INC;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic tk, input logic en);
        logic acc;
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, tk, en, 1'b1, acc);
    endtask

    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] ws, input logic tk);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) step(1'b1, we, addr, wd, ws, tk, 1'b1, 1'b1, acc);
        req_valid = 1'b0;
    endtask

    // Reset asserted a few ns after a rising edge, checked before any edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        req_valid = 1'b0; trigger_edge = 1'b0; rsp_ready = 1'b0; cnt_en = 1'b1;
        #1;
        chk("rst_count", count, 64'h0);
        chk("rst_countcmp", countcmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_msip", msip, 64'h0);
        chk("rst_req_ready", 64'(req_ready), 64'h1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rst_rsp_err", 64'(rsp_err), 64'h0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== mon_exp) begin
                    n_errors++;
                    $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             rsp_err, rsp_rdata, mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] amap [0:5] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h1234};

    initial begin
        logic        acc;
        logic [15:0] a;
        int          idx;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
        req_wstrb = 4'h0; rsp_ready = 1'b0; cnt_en = 1'b1; trigger_edge = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // compare register write / read-back, response one cycle after accept
        bus(1'b1, 16'h4000, 32'h10, 4'hF, 1'b0);
        bus(1'b1, 16'h4004, 32'h0, 4'hF, 1'b0);
        bus(1'b0, 16'h4000, 32'h0, 4'h0, 1'b0);
        chk("rd_latency_valid", 64'(rsp_valid), 64'h1);
        chk("rd_cmp_lo", 64'(rsp_rdata), 64'h10);
        chk("rd_cmp_err", 64'(rsp_err), 64'h0);

        // carry from low half into high half
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        bus(1'b1, 16'hBFFC, 32'h0, 4'hF, 1'b0);
        idle(1'b1, 1'b1);
        chk("count_carry", count, 64'h0000_0001_0000_0000);

        // all-ones wraps to zero
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 1'b0);
        bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 1'b0);
        idle(1'b1, 1'b1);
        chk("count_wrap", count, 64'h0);

        // write to count lo on the same cycle as a tick
        bus(1'b1, 16'hBFFC, 32'h7, 4'hF, 1'b0);
        bus(1'b1, 16'hBFF8, 32'h1234, 4'hF, 1'b0);
        idle(1'b0, 1'b1);
        bus(1'b1, 16'hBFF8, 32'h5, 4'hF, 1'b1);
        chk("count_collision", count, 64'h0000_0007_0000_0005);

        // response held for 5 cycles while a second request waits
        idle(1'b0, 1'b1);
        bus(1'b0, 16'h4000, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'h4004, 32'h99, 4'hF, 1'b0, 1'b1, 1'b0, acc);
        chk("hold_rdata", 64'(rsp_rdata), 64'h10);
        chk("hold_req_ready", 64'(req_ready), 64'h0);
        step(1'b1, 1'b1, 16'h4004, 32'h99, 4'hF, 1'b0, 1'b1, 1'b1, acc);
        step(1'b1, 1'b1, 16'h4004, 32'h99, 4'hF, 1'b0, 1'b1, 1'b1, acc);
        req_valid = 1'b0;
        idle(1'b0, 1'b1);
        chk("cmp_after_hold", countcmp, 64'h0000_0099_0000_0010);

        // unmapped read, msip write through byte lane 0
        bus(1'b0, 16'h1234, 32'h0, 4'h0, 1'b0);
        bus(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'h1, 1'b0);
        idle(1'b0, 1'b1);
        chk("msip_set", msip, 64'h1);

        // frozen counter ignores ticks
        bus(1'b1, 16'hBFF8, 32'h42, 4'hF, 1'b0);
        bus(1'b1, 16'hBFFC, 32'hAB, 4'hF, 1'b0);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1, 1'b0);
        chk("count_frozen", count, 64'h0000_00AB_0000_0042);

        // reset with a response outstanding
        bus(1'b0, 16'hBFF8, 32'h0, 4'h0, 1'b0);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            idx = $urandom_range(0, 6);
            if (idx == 6) a = 16'($urandom_range(0, 65535));
            else a = amap[idx] | 16'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), acc);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
